// File: rtl/banked_mem_responder_pkg.sv
// Shared constants, types and address-split helpers for the four-bank memory responder.
package banked_mem_responder_pkg;

   localparam int NUM_BANKS       = 4;
   localparam int ADDR_W          = 16;
   localparam int DATA_W          = 16;
   localparam int BANK_SEL_LSB    = 1;
   localparam int BANK_SEL_MSB    = 2;
   localparam int ROW_LSB         = 3;
   localparam int ROW_W           = 13;
   localparam int BUSY_CYCLES_DEF = 4;
   localparam int RD_LATENCY_DEF  = 2;

   typedef logic [BANK_SEL_MSB-BANK_SEL_LSB:0] bank_sel_t;
   typedef logic [ROW_W-1:0]                   row_t;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
   } rd_stage_t;

   function automatic bank_sel_t bank_of(input logic [ADDR_W-1:0] a);
      return a[BANK_SEL_MSB:BANK_SEL_LSB];
   endfunction

   function automatic row_t row_of(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:ROW_LSB];
   endfunction

endpackage

// File: rtl/banked_mem_responder_mem_bank.sv
// One storage bank: 8192 x 16 words, synchronous write, combinational read.
// Contents are deliberately left out of reset so data survives a controller reset.
module mem_bank
   import banked_mem_responder_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  row_t              row,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0] mem [2**ROW_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[row] <= data_in;
      end
   end

   assign data_out = mem[row];

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank memory responder: per-request legality/busy arbitration, per-bank occupancy
// down-counters, and a fixed-latency read return pipeline.
module banked_mem_responder
   import banked_mem_responder_pkg::*;
#(
   parameter int BUSY_CYCLES = BUSY_CYCLES_DEF,
   parameter int RD_LATENCY  = RD_LATENCY_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    data_in,
   input  logic                 wr,
   input  logic                 rd,
   output logic [DATA_W-1:0]    data_out,
   output logic [NUM_BANKS-1:0] busy,
   output logic                 stall,
   output logic                 err
);

   localparam int              CNT_W     = $clog2(BUSY_CYCLES + 1);
   localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES - 1);

   bank_sel_t            bank;
   row_t                 row;
   logic                 req;
   logic                 illegal;
   logic                 accept;
   logic [NUM_BANKS-1:0] busy_raw;
   logic [NUM_BANKS-1:0] wr_en;
   logic [CNT_W-1:0]     cnt        [NUM_BANKS];
   logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
   rd_stage_t            pipe       [RD_LATENCY];

   // Outputs are gated by rst so nothing leaks during the first reset cycle,
   // before the synchronous clear has taken effect.
   always_comb begin
      bank     = bank_of(addr);
      row      = row_of(addr);
      req      = wr | rd;
      illegal  = req & ((wr & rd) | addr[0]);
      busy_raw = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         busy_raw[i] = (cnt[i] != '0);
      end
      accept = ~rst & req & ~illegal & ~busy_raw[bank];
      err    = ~rst & illegal;
      stall  = ~rst & req & ~illegal & busy_raw[bank];
      busy   = rst ? '0 : busy_raw;
      wr_en  = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         wr_en[i] = accept & wr & (bank == bank_sel_t'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            if (accept && (bank == bank_sel_t'(i))) begin
               cnt[i] <= BUSY_LOAD;
            end else if (busy_raw[i]) begin
               cnt[i] <= cnt[i] - CNT_W'(1);
            end
         end
      end
   end

   // Read data is sampled in the acceptance cycle, so a write committed on an
   // earlier edge is always visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < RD_LATENCY; s++) begin
            pipe[s].valid <= 1'b0;
            pipe[s].data  <= '0;
         end
      end else begin
         pipe[0].valid <= accept & rd;
         pipe[0].data  <= (accept & rd) ? bank_rdata[bank] : '0;
         for (int s = 1; s < RD_LATENCY; s++) begin
            pipe[s] <= pipe[s-1];
         end
      end
   end

   assign data_out = (~rst & pipe[RD_LATENCY-1].valid) ? pipe[RD_LATENCY-1].data : '0;

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      mem_bank u_bank (
         .clk      (clk),
         .wr_en    (wr_en[g]),
         .row      (row),
         .data_in  (data_in),
         .data_out (bank_rdata[g])
      );
   end

endmodule

// File: doc/banked_mem_responder.md
BANKED_MEM_RESPONDER -- requirements
Module: banked_mem_responder

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 Parameter BUSY_CYCLES, default 4: cycles a bank is occupied per accepted access, counting the acceptance cycle.
REQ-003 Parameter RD_LATENCY, default 2: cycles from read acceptance to data on data_out.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 addr  in  16  byte address; addr[2:1] selects the bank, addr[15:3] selects the row, addr[0] must be 0.
REQ-007 data_in  in  16  write data.
REQ-008 wr  in  1  write request.
REQ-009 rd  in  1  read request.
REQ-010 data_out  out  16  read return data.
REQ-011 busy  out  4  per-bank occupied flags; bit i covers bank i.
REQ-012 stall  out  1  the current request targets a busy bank and is not accepted.
REQ-013 err  out  1  the current request is illegal and is not accepted.

Function
REQ-014 Request = wr|rd. A request SHALL be accepted only if all three hold: busy[addr[2:1]]==0, not (wr&rd), addr[0]==0.
REQ-015 Illegal request: wr&rd, or addr[0]==1 with a request. It SHALL assert err combinationally in the same cycle and SHALL change no state.
REQ-016 Legal request to a busy bank: stall SHALL assert combinationally in the same cycle, with no state change. The requester holds the request and retries.
REQ-017 err SHALL take priority over stall; at most one of the two is high in any cycle.
REQ-018 Each bank SHALL have a down-counter.
  - Acceptance in cycle N loads BUSY_CYCLES-1.
  - busy[i] = (counter != 0), so the bank is busy in N+1..N+BUSY_CYCLES-1 and free in N+BUSY_CYCLES.
REQ-019 Banks SHALL operate independently. A new acceptance is possible every cycle if successive requests target different free banks.
REQ-020 Write accepted in cycle N SHALL update storage at the clock edge ending cycle N.
REQ-021 Read accepted in cycle N SHALL sample storage in cycle N and present the word on data_out in cycle N+RD_LATENCY. The value comes from a registered pipeline of depth RD_LATENCY, with a valid bit per stage.
REQ-022 data_out SHALL be 16'h0000 in any cycle with no returning read.
REQ-023 Read after write to the same address SHALL return the new data when the read is accepted in a later cycle than the write.
REQ-024 Accepted reads SHALL return in acceptance order, one per cycle, and SHALL never be dropped except by reset.
REQ-025 The read pipeline SHALL be independent of bank counters. A returning read does not block acceptance on any bank.

Reset
REQ-026 While rst=1: all bank counters=0, busy=4'b0000, all pipeline valid bits=0, data_out=16'h0000, and no request is accepted.
REQ-027 stall and err SHALL be 0 while rst=1.
REQ-028 Reset mid-operation SHALL discard in-flight reads. No data appears after rst deasserts.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-030 A shared package SHALL hold:
  - bank count (4);
  - bank-select bit positions [2:1];
  - row width (13);
  - BUSY_CYCLES and RD_LATENCY defaults.
REQ-031 One sub-module, mem_bank, SHALL be instantiated 4 times.
  - Contents: 8192x16 storage, synchronous write, combinational read.
  - Ports: clk, wr_en, row, data_in, data_out.
REQ-032 Arbitration, counters and the read pipeline SHALL reside in banked_mem_responder.

Verification
REQ-033 Write 16'hA5A5 to 16'h0010 (bank 0) at N -> busy[0]=1 in N+1..N+3, 0 at N+4; stall=0 and err=0 at N.
REQ-034 Streamed reads of 16'h0010, 0012, 0014, 0016 in N..N+3 (preloaded 1,2,3,4) -> data_out = 1,2,3,4 in N+2..N+5, and 0 at N+6.
REQ-035 Read 16'h0010 at N, read 16'h0018 (bank 0 again) at N+1 -> stall=1 in N+1..N+3; accepted at N+4; data at N+6.
REQ-036 wr=rd=1 at 16'h0020 -> err=1, stall=0, busy unchanged. rd at 16'h0021 -> err=1, no data returned.
REQ-037 Write 16'h1234 to 16'h0040 at N, read 16'h0040 at N+4 -> data_out=16'h1234 at N+6.
REQ-038 Read accepted at N, rst=1 at N+1 -> data_out=0 and busy=0 from N+2 onward; no late data after rst drops.
